// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: opcodes and FSM states.
package mdu_seq_pkg;

  localparam logic [4:0] OPNULL   = 5'd0;
  localparam logic [4:0] OPMUL    = 5'd20;
  localparam logic [4:0] OPMULH   = 5'd21;
  localparam logic [4:0] OPMULHSU = 5'd22;
  localparam logic [4:0] OPMULHU  = 5'd23;
  localparam logic [4:0] OPDIV    = 5'd24;
  localparam logic [4:0] OPDIVU   = 5'd25;
  localparam logic [4:0] OPREM    = 5'd26;
  localparam logic [4:0] OPREMU   = 5'd27;

  localparam logic [31:0] ZERO = 32'd0;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

endpackage

// File: rtl/mdu_seq_iter_core.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on {hi, lo}.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] iHi,
  input  logic [WIDTH-1:0] iLo,
  input  logic [WIDTH-1:0] iB,
  input  logic             iDiv,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oQBit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, iHi} + (iLo[0] ? {1'b0, iB} : {(WIDTH+1){1'b0}});
    shifted = {iHi, iLo[WIDTH-1]};
    diff    = shifted - {1'b0, iB};
    oQBit   = 1'b0;
    if (iDiv) begin
      // Partial remainder is always < divisor, so the trial fits in WIDTH+1 bits.
      oQBit = ~diff[WIDTH];
      oHi   = oQBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      oLo   = {iLo[WIDTH-2:0], 1'b0};
    end else begin
      oHi   = sum[WIDTH:1];
      oLo   = {sum[0], iLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide unit: FSM, sign handling, fast paths and result register.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic              iFlush,
  input  logic [CTRL_W-1:0] iControl,
  input  logic [WIDTH-1:0]  iA,
  input  logic [WIDTH-1:0]  iB,
  output logic              oReady,
  output logic              oValid,
  output logic [WIDTH-1:0]  oResult
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [CTRL_W-1:0] op_q, op_d;
  logic              neg_q, neg_d, negr_q, negr_d, fast_q, fast_d, div_q, div_d;
  logic              valid_q, valid_d, ready_q, ready_d;

  logic [WIDTH-1:0]   hi_n, lo_n, abs_a, abs_b, fast_res, quot, rem, fix_res;
  logic [2*WIDTH-1:0] prod_s;
  logic               q_bit, a_sgn, b_sgn, s_a, s_b, is_mul, is_div, b_zero, ovf, fast;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .iHi(hi_q), .iLo(lo_q), .iB(b_q), .iDiv(div_q),
    .oHi(hi_n), .oLo(lo_n), .oQBit(q_bit)
  );

  // Acceptance-time decode of the incoming request.
  always_comb begin
    is_mul = (iControl == CTRL_W'(OPMUL))  || (iControl == CTRL_W'(OPMULH)) ||
             (iControl == CTRL_W'(OPMULHSU)) || (iControl == CTRL_W'(OPMULHU));
    is_div = (iControl == CTRL_W'(OPDIV))  || (iControl == CTRL_W'(OPDIVU)) ||
             (iControl == CTRL_W'(OPREM))  || (iControl == CTRL_W'(OPREMU));
    b_sgn  = (iControl == CTRL_W'(OPMULH)) || (iControl == CTRL_W'(OPDIV)) ||
             (iControl == CTRL_W'(OPREM));
    a_sgn  = b_sgn || (iControl == CTRL_W'(OPMULHSU));
    s_a    = a_sgn & iA[WIDTH-1];
    s_b    = b_sgn & iB[WIDTH-1];
    abs_a  = s_a ? -iA : iA;
    abs_b  = s_b ? -iB : iB;
    b_zero = (iB == '0);
    ovf    = ((iControl == CTRL_W'(OPDIV)) || (iControl == CTRL_W'(OPREM))) &&
             (iA == MOST_NEG) && (&iB);
    fast   = !(is_mul || is_div) || (is_div && (b_zero || ovf));
    fast_res = '0;
    if (is_div && b_zero)
      fast_res = ((iControl == CTRL_W'(OPDIV)) || (iControl == CTRL_W'(OPDIVU))) ? '1 : iA;
    else if (ovf)
      fast_res = (iControl == CTRL_W'(OPDIV)) ? iA : '0;
  end

  // Final sign correction and half selection.
  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot   = neg_q ? -lo_q : lo_q;
    rem    = negr_q ? -hi_q : hi_q;
    case (op_q)
      CTRL_W'(OPMUL):                    fix_res = prod_s[WIDTH-1:0];
      CTRL_W'(OPMULH), CTRL_W'(OPMULHSU),
      CTRL_W'(OPMULHU):                  fix_res = prod_s[2*WIDTH-1:WIDTH];
      CTRL_W'(OPDIV), CTRL_W'(OPDIVU):   fix_res = quot;
      CTRL_W'(OPREM), CTRL_W'(OPREMU):   fix_res = rem;
      default:                           fix_res = '0;
    endcase
    if (fast_q) fix_res = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    fast_d  = fast_q;
    div_d   = div_q;
    valid_d = 1'b0;
    ready_d = ready_q;
    case (state_q)
      IDLE: if (iStart) begin
        op_d    = iControl;
        div_d   = is_div;
        neg_d   = s_a ^ s_b;
        negr_d  = s_a;
        b_d     = abs_b;
        hi_d    = '0;
        cnt_d   = CW'(WIDTH);
        fast_d  = fast;
        lo_d    = fast ? fast_res : abs_a;
        state_d = fast ? FIX : CALC;
        ready_d = 1'b0;
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n | {{(WIDTH-1){1'b0}}, q_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle start.
    if (iFlush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ready_d = 1'b1;
      res_d   = res_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      fast_q  <= 1'b0;
      div_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      fast_q  <= fast_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign oReady  = ready_q;
  assign oValid  = valid_q;
  assign oResult = res_q;

endmodule
